// File: rtl/monitoreo_pkg.sv
// Shared types and defaults for the zone-scanning temperature monitor.
// Holds temperature width, scheduler states and default sizing.
package monitoreo_pkg;

    localparam int W_TEMP      = 11;
    localparam int N_ZONAS_DEF = 4;
    localparam int DWELL_DEF   = 8;

    typedef logic signed [W_TEMP-1:0] temp_t;

    typedef enum logic [1:0] {
        REPOSO,
        CONMUTA,
        ESPERA,
        CAPTURA
    } sched_estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: grants the lowest requesting index strictly
// after the pointer, wrapping from N-1 back to 0.
module arbitro_rr #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          valid_o
);

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_i) + k) % N;
            if (req_i[IW'(idx)]) begin
                grant_o = IW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/planificador_zonas.sv
// Round-robin scheduler time-sharing one temperature monitor across zones.
// Selects a zone, clears the monitor, dwells, then captures its verdict.
module planificador_zonas #(
    parameter  int N_ZONAS = monitoreo_pkg::N_ZONAS_DEF,
    parameter  int DWELL   = monitoreo_pkg::DWELL_DEF,
    parameter  int W_TEMP  = monitoreo_pkg::W_TEMP,
    localparam int ZW      = $clog2(N_ZONAS),
    localparam int CW      = $clog2(DWELL)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        habilitar,
    input  logic [N_ZONAS-1:0]          zona_req,
    input  logic [N_ZONAS*W_TEMP-1:0]   temp_zonas,
    input  logic [N_ZONAS-1:0]          clr_alertas,
    input  logic                        alerta_in,
    input  logic                        calefactor_in,
    input  logic                        ventilador_in,
    output logic signed [W_TEMP-1:0]    temp_sel,
    output logic                        monitor_rst_n,
    output logic [ZW-1:0]               zona_activa,
    output logic [N_ZONAS-1:0]          zona_ack,
    output logic [N_ZONAS-1:0]          alerta_zona,
    output logic [N_ZONAS-1:0]          calefactor_zona,
    output logic [N_ZONAS-1:0]          ventilador_zona,
    output logic                        ocupado
);

    import monitoreo_pkg::*;

    sched_estado_t              estado_q, estado_d;
    logic [ZW-1:0]              ptr_q, ptr_d;
    logic [ZW-1:0]              zona_q, zona_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic signed [W_TEMP-1:0]   temp_q, temp_d;
    logic                       mrst_q, mrst_d;
    logic [N_ZONAS-1:0]         ack_q, ack_d;
    logic [N_ZONAS-1:0]         alerta_q, alerta_d;
    logic [N_ZONAS-1:0]         cal_q, cal_d;
    logic [N_ZONAS-1:0]         ven_q, ven_d;

    logic [N_ZONAS-1:0]         req_hab;
    logic [ZW-1:0]              gnt;
    logic                       gnt_v;
    logic signed [W_TEMP-1:0]   t_gnt;
    logic signed [W_TEMP-1:0]   t_act;

    assign req_hab = zona_req & {N_ZONAS{habilitar}};
    assign t_gnt   = temp_zonas[int'(gnt) * W_TEMP +: W_TEMP];
    assign t_act   = temp_zonas[int'(zona_q) * W_TEMP +: W_TEMP];

    arbitro_rr #(
        .N (N_ZONAS)
    ) u_arbitro (
        .req_i   (req_hab),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .valid_o (gnt_v)
    );

    // Next-state and registered-output computation for the scan FSM.
    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        zona_d   = zona_q;
        cnt_d    = cnt_q;
        temp_d   = temp_q;
        mrst_d   = mrst_q;
        ack_d    = '0;
        alerta_d = alerta_q & ~clr_alertas;
        cal_d    = cal_q;
        ven_d    = ven_q;
        unique case (estado_q)
            REPOSO: begin
                if (gnt_v) begin
                    estado_d = CONMUTA;
                    zona_d   = gnt;
                    ptr_d    = gnt;
                    temp_d   = t_gnt;
                    mrst_d   = 1'b0;
                end
            end
            CONMUTA: begin
                estado_d = ESPERA;
                mrst_d   = 1'b1;
                cnt_d    = CW'(DWELL - 1);
                temp_d   = t_act;
            end
            ESPERA: begin
                temp_d = t_act;
                if (cnt_q == '0) begin
                    estado_d      = CAPTURA;
                    ack_d[zona_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURA: begin
                alerta_d[zona_q] = alerta_d[zona_q] | alerta_in;
                cal_d[zona_q]    = calefactor_in;
                ven_d[zona_q]    = ventilador_in;
                if (gnt_v) begin
                    estado_d = CONMUTA;
                    zona_d   = gnt;
                    ptr_d    = gnt;
                    temp_d   = t_gnt;
                    mrst_d   = 1'b0;
                end else begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    // State and output registers; reset holds the monitor cleared.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            estado_q <= REPOSO;
            ptr_q    <= ZW'(N_ZONAS - 1);
            zona_q   <= '0;
            cnt_q    <= '0;
            temp_q   <= '0;
            mrst_q   <= 1'b0;
            ack_q    <= '0;
            alerta_q <= '0;
            cal_q    <= '0;
            ven_q    <= '0;
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
            zona_q   <= zona_d;
            cnt_q    <= cnt_d;
            temp_q   <= temp_d;
            mrst_q   <= mrst_d;
            ack_q    <= ack_d;
            alerta_q <= alerta_d;
            cal_q    <= cal_d;
            ven_q    <= ven_d;
        end
    end

    assign temp_sel        = temp_q;
    assign monitor_rst_n   = mrst_q;
    assign zona_activa     = zona_q;
    assign zona_ack        = ack_q;
    assign alerta_zona     = alerta_q;
    assign calefactor_zona = cal_q;
    assign ventilador_zona = ven_q;
    assign ocupado         = (estado_q != REPOSO);

endmodule

// File: tb/tb_planificador_zonas.sv
// Bench for planificador_zonas: directed plan steps plus random traffic,
// every cycle compared against a service-age reference model.
module tb_planificador_zonas;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int W  = 11;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               habilitar;
    logic [N-1:0]       zona_req;
    logic [N*W-1:0]     temp_zonas;
    logic [N-1:0]       clr_alertas;
    logic               alerta_in;
    logic               calefactor_in;
    logic               ventilador_in;
    logic signed [W-1:0] temp_sel;
    logic               monitor_rst_n;
    logic [1:0]         zona_activa;
    logic [N-1:0]       zona_ack;
    logic [N-1:0]       alerta_zona;
    logic [N-1:0]       calefactor_zona;
    logic [N-1:0]       ventilador_zona;
    logic               ocupado;

    int vectors = 0;
    int miss    = 0;

    // Reference model: a service is described by its age in cycles
    // since the grant (1 = clear cycle, 2..D+1 = dwell, D+2 = capture).
    bit                 m_busy;
    int                 m_age;
    int                 m_zone;
    int                 m_ptr;
    logic signed [W-1:0] m_temp;
    logic               m_mrst;
    logic [N-1:0]       m_ack;
    logic [N-1:0]       m_al;
    logic [N-1:0]       m_cal;
    logic [N-1:0]       m_ven;

    planificador_zonas #(
        .N_ZONAS (N),
        .DWELL   (D),
        .W_TEMP  (W)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .habilitar       (habilitar),
        .zona_req        (zona_req),
        .temp_zonas      (temp_zonas),
        .clr_alertas     (clr_alertas),
        .alerta_in       (alerta_in),
        .calefactor_in   (calefactor_in),
        .ventilador_in   (ventilador_in),
        .temp_sel        (temp_sel),
        .monitor_rst_n   (monitor_rst_n),
        .zona_activa     (zona_activa),
        .zona_ack        (zona_ack),
        .alerta_zona     (alerta_zona),
        .calefactor_zona (calefactor_zona),
        .ventilador_zona (ventilador_zona),
        .ocupado         (ocupado)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] tz(int i);
        return temp_zonas[i*W +: W];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!arst_n) begin
            m_busy = 0; m_age = 0; m_zone = 0; m_ptr = N - 1;
            m_temp = '0; m_mrst = 0; m_ack = '0;
            m_al = '0; m_cal = '0; m_ven = '0;
        end else begin
            m_ack = '0;
            m_al  = m_al & ~clr_alertas;
            if (m_busy) begin
                if (m_age == D + 2) begin
                    m_al[m_zone]  = m_al[m_zone] | alerta_in;
                    m_cal[m_zone] = calefactor_in;
                    m_ven[m_zone] = ventilador_in;
                    m_busy = 0;
                end else begin
                    m_age++;
                    m_temp = tz(m_zone);
                    m_mrst = 1'b1;
                    if (m_age == D + 2) m_ack[m_zone] = 1'b1;
                end
            end
            if (!m_busy && habilitar && (|zona_req)) begin
                for (int k = 1; k <= N; k++) begin
                    int z;
                    z = (m_ptr + k) % N;
                    if (!m_busy && zona_req[z]) begin
                        m_busy = 1; m_zone = z; m_ptr = z; m_age = 1;
                        m_temp = tz(z); m_mrst = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        vectors++;
        check("temp_sel", 32'(temp_sel), 32'(m_temp));
        check("monitor_rst_n", 32'(monitor_rst_n), 32'(m_mrst));
        check("zona_activa", 32'(zona_activa), 32'(m_zone));
        check("zona_ack", 32'(zona_ack), 32'(m_ack));
        check("alerta_zona", 32'(alerta_zona), 32'(m_al));
        check("calefactor_zona", 32'(calefactor_zona), 32'(m_cal));
        check("ventilador_zona", 32'(ventilador_zona), 32'(m_ven));
        check("ocupado", 32'(ocupado), 32'(m_busy));
        check("ack_onehot", 32'($onehot0(zona_ack)), 32'd1);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        arst_n = 0; habilitar = 1; zona_req = '1; temp_zonas = '0;
        clr_alertas = '0; alerta_in = 0;
        calefactor_in = 0; ventilador_in = 0;
        for (int i = 0; i < N; i++) temp_zonas[i*W +: W] = W'(10 * i + 5);

        // Reset held with requests pending.
        run(3);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_mrst", 32'(monitor_rst_n), 32'd0);
        check("rst_ack", 32'(zona_ack), 32'd0);
        arst_n = 1;
        step();
        check("first_grant", 32'(zona_activa), 32'd0);
        check("first_busy", 32'(ocupado), 32'd1);

        // Fairness: all requests held, acks 0,1,2,3,0 every D+2 cycles.
        for (int k = 0; k < 5; k++) begin
            run(k == 0 ? D + 1 : D + 2);
            check("fair_ack", 32'(zona_ack), 32'(1 << (k % N)));
        end
        zona_req = '0;
        step();
        check("fair_idle", 32'(ocupado), 32'd0);

        // Single request on zone 2.
        temp_zonas[2*W +: W] = W'(200);
        zona_req = 4'b0100;
        step();
        check("single_zone", 32'(zona_activa), 32'd2);
        check("single_temp", 32'(temp_sel), 32'd200);
        check("single_mrst", 32'(monitor_rst_n), 32'd0);
        zona_req = '0;
        run(D + 1);
        check("single_ack", 32'(zona_ack), 32'b0100);
        step();
        check("single_ack_end", 32'(zona_ack), 32'd0);
        check("single_idle", 32'(ocupado), 32'd0);

        // Sticky alarms: zone 1 alarms, zone 2 does not.
        zona_req = 4'b0010; alerta_in = 1;
        step();
        zona_req = '0;
        run(D + 2);
        alerta_in = 0; zona_req = 4'b0100;
        step();
        zona_req = '0;
        run(D + 2);
        check("sticky_hold", 32'(alerta_zona), 32'b0010);
        clr_alertas = 4'b0010;
        step();
        clr_alertas = '0;
        check("sticky_clr", 32'(alerta_zona), 32'd0);
        zona_req = 4'b0010; alerta_in = 1;
        step();
        zona_req = '0;
        run(D + 1);
        clr_alertas = 4'b0010;
        step();
        clr_alertas = '0; alerta_in = 0;
        check("set_beats_clr", 32'(alerta_zona), 32'b0010);

        // habilitar dropped during the third dwell cycle of zone 0.
        arst_n = 0;
        step();
        arst_n = 1; zona_req = '1;
        step();
        run(3);
        habilitar = 0;
        run(D - 2);
        check("hab_ack", 32'(zona_ack), 32'b0001);
        step();
        check("hab_idle", 32'(ocupado), 32'd0);
        run(5);
        check("hab_stay", 32'(ocupado), 32'd0);
        habilitar = 1;
        step();
        check("hab_resume", 32'(zona_activa), 32'd1);

        // Reset during the fifth dwell cycle aborts the service.
        arst_n = 0;
        step();
        arst_n = 1; zona_req = 4'b0001;
        step();
        zona_req = '0;
        run(5);
        arst_n = 0;
        step();
        check("abort_busy", 32'(ocupado), 32'd0);
        check("abort_ack", 32'(zona_ack), 32'd0);
        check("abort_temp", 32'(temp_sel), 32'd0);
        run(2);
        arst_n = 1;
        run(D + 4);
        check("abort_no_ack", 32'(zona_ack), 32'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            zona_req      = N'($urandom);
            habilitar     = ($urandom % 8) != 0;
            temp_zonas    = {$urandom, $urandom};
            alerta_in     = $urandom % 2;
            calefactor_in = $urandom % 2;
            ventilador_in = $urandom % 2;
            clr_alertas   = ($urandom % 6 == 0) ? N'($urandom) : '0;
            arst_n        = ($urandom % 150) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
